gpio_hex_display: RTL and testbench
===================================

# gpio_hex_display

- Display-side consumer of the CPU's GPIO output port.
- Takes the 32-bit word the core drives on an output register (normally `io2_out`) and shows it as eight hex digits on a multiplexed, common-anode seven-segment display.
- Runs a scan state machine with programmable dwell and ghost-suppression dead time.
- Latches the value only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface

Parameters:
- `TICK_CYCLES`, default 50000: clock cycles each digit is lit (SHOW dwell); must be ≥ 1.
- `DEAD_CYCLES`, default 2: clock cycles with all anodes off between digits; must be ≥ 1.
- `BLANK_LZ`, default 1: 1 enables leading-zero blanking.

Ports:
- `clk`  in  1: system clock, rising edge. One clock; all state is in this domain.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `value_in`  in  32: word to display; nibble k drives digit k (digit 0 is the rightmost).
- `dp_in`  in  8: decimal-point request; bit k lights the DP of digit k.
- `enable`  in  1: display enable. Sampled synchronously.
- `seg_n`  out  7: segment drives, active-low; bit 0 = a … bit 6 = g.
- `dp_n`  out  1: decimal-point drive, active-low.
- `an_n`  out  8: digit anode enables, active-low, one-hot-low when lit.
- `digit_idx`  out  3: index of the current or last-lit digit (debug).

## Operation

- States: IDLE, DEAD, SHOW. A single down-counter `cnt` serves both DEAD and SHOW.
  - Width: clog2(max(TICK_CYCLES, DEAD_CYCLES)).
- Reset (async) values:
  - state = IDLE, `digit_idx` = 7, `cnt` = 0
  - shadow value = 0, shadow dp = 0
  - `an_n` = 8'hFF, `seg_n` = 7'h7F, `dp_n` = 1
- IDLE → DEAD when `enable` = 1; `cnt` loads DEAD_CYCLES-1.
- Any state → IDLE on any edge where `enable` = 0. Outputs return to their reset values; `digit_idx` returns to 7.
- DEAD:
  - `an_n` = 8'hFF, `seg_n` = 7'h7F, `dp_n` = 1.
  - When `cnt` = 0: go to SHOW, `digit_idx` ← `digit_idx`+1 (mod 8), `cnt` ← TICK_CYCLES-1. Otherwise decrement `cnt`.
- Frame start is the DEAD→SHOW edge where `digit_idx` wraps 7→0. On that same edge:
  - shadow value ← `value_in`, shadow dp ← `dp_in`.
  - Digit 0's outputs are decoded directly from these new values.
- SHOW:
  - `an_n` = ~(1 << `digit_idx`).
  - `seg_n` = hex decode of shadow nibble `digit_idx`.
  - `dp_n` = ~shadow_dp[`digit_idx`].
  - When `cnt` = 0: go to DEAD with `cnt` ← DEAD_CYCLES-1. Otherwise decrement `cnt`.
- Hex decode (`seg_n`, active-low):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Leading-zero blanking (BLANK_LZ = 1):
  - Digit k > 0 shows `seg_n` = 7'h7F if shadow nibbles k..7 are all zero.
  - Digit 0 is never blanked.
  - The anode is still driven for a blanked digit.
  - `dp_n` follows `dp_in` regardless of blanking.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing

- Each digit slot = DEAD_CYCLES + TICK_CYCLES cycles; frame period = 8 × (TICK_CYCLES + DEAD_CYCLES).
- First lit cycle after `enable` rises: edge 1 enters DEAD; SHOW of digit 0 begins DEAD_CYCLES edges later.
- `value_in` / `dp_in` are sampled only at frame start.
  - Changes mid-frame are invisible until the next frame.
  - Worst-case display latency is one frame period plus one cycle.
- `enable` falling: `an_n` = FF on the first edge where `enable` = 0 is sampled, even mid-SHOW.
- `rst_n` assertion mid-operation: outputs take reset values immediately, with no clock needed. Release is synchronous to the next `clk` edge.

## Test plan

- Reset values: assert `rst_n` = 0 mid-SHOW → `an_n` = FF, `seg_n` = 7F, `dp_n` = 1, `digit_idx` = 7 without a clock edge. Hold `enable` = 0 after release → outputs stay at reset values.
- Blanking (TICK = 4, DEAD = 1, BLANK_LZ = 1), `value_in` = 32'h0000_00A5, `dp_in` = 8'h02:
  - digit 0: `an_n` = FE, `seg_n` = 12, `dp_n` = 1
  - digit 1: `an_n` = FD, `seg_n` = 08, `dp_n` = 0
  - digits 2–7: `seg_n` = 7F, `dp_n` = 1
- Full decode: `value_in` = 32'h0123_4567 then 32'h89AB_CDEF → each digit's `seg_n` matches the table. Value 0 → digit 0 shows 40 and digits 1–7 show 7F.
- Scan timing (TICK = 4, DEAD = 1):
  - Each `an_n` low pulse is exactly 4 cycles, separated by exactly 1 cycle of FF.
  - Digits appear in order 0..7; frame repeats every 40 cycles.
  - `digit_idx` wraps 7→0.
- No tearing: change `value_in` 32'h1111_1111 → 32'h2222_2222 while digit 3 is lit → digits 4–7 still show 79. Next frame shows 24 on all digits.
- Enable drop/restore: `enable` = 0 during digit 5 SHOW → next edge `an_n` = FF, `digit_idx` = 7. Re-assert → after DEAD_CYCLES, digit 0 lit with a freshly sampled `value_in`.

Source files
------------

// File: rtl/gpio_hex_display.sv
// gpio_hex_display
// Shows a 32-bit GPIO output word as eight hex digits on a multiplexed,
// common-anode seven-segment display. A scan FSM alternates a short
// all-off DEAD gap (ghost suppression) with a SHOW dwell for each digit.
// The displayed word is latched only when the scan wraps back to digit 0,
// so one frame never mixes digits from two different words.
// Every output is registered: the next-cycle drive values are decoded
// from the next-state signals and captured on the clock edge.

module gpio_hex_display #(
    parameter int TICK_CYCLES = 50000,
    parameter int DEAD_CYCLES = 2,
    parameter int BLANK_LZ    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value_in,
    input  logic [7:0]  dp_in,
    input  logic        enable,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  an_n,
    output logic [2:0]  digit_idx
);

    // One counter covers both the DEAD gap and the SHOW dwell, so it is
    // sized for the longer of the two (never narrower than one bit).
    localparam int MAX_CYC = (TICK_CYCLES > DEAD_CYCLES) ? TICK_CYCLES : DEAD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] TICK_LOAD = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        SHOW = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_d;
    logic [31:0]      shadow_val_q, shadow_val_d;
    logic [7:0]       shadow_dp_q, shadow_dp_d;
    logic [7:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;
    logic [3:0]       nibble;
    logic             blank;

    // Active-low segment pattern for one hex nibble (bit 0 = a ... bit 6 = g).
    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // True when nibbles k..7 of the word are all zero (leading-zero test).
    function automatic logic upper_zero(input logic [31:0] v, input logic [2:0] k);
        return (v >> {k, 2'b00}) == 32'd0;
    endfunction

    // Next-state logic: scan sequencing, counter reloads and frame-start latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = digit_idx;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = 3'd7;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = DEAD;
                    cnt_d   = DEAD_LOAD;
                end
                DEAD: begin
                    if (cnt_q == '0) begin
                        state_d = SHOW;
                        idx_d   = digit_idx + 3'd1;
                        cnt_d   = TICK_LOAD;
                        if (digit_idx == 3'd7) begin
                            shadow_val_d = value_in;
                            shadow_dp_d  = dp_in;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == '0) begin
                        state_d = DEAD;
                        cnt_d   = DEAD_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = 3'd7;
                end
            endcase
        end
    end

    // Output decode from the next-state values so digit 0 of a new frame
    // already reflects the word being latched on that same edge.
    always_comb begin
        an_d   = 8'hFF;
        seg_d  = 7'h7F;
        dp_d   = 1'b1;
        nibble = shadow_val_d[{idx_d, 2'b00} +: 4];
        blank  = (BLANK_LZ != 0) && (idx_d != 3'd0) && upper_zero(shadow_val_d, idx_d);
        if (state_d == SHOW) begin
            an_d  = ~(8'b1 << idx_d);
            seg_d = blank ? 7'h7F : hex_decode(nibble);
            dp_d  = ~shadow_dp_d[idx_d];
        end
    end

    // State, counter, shadow registers and registered display drives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            digit_idx    <= 3'd7;
            shadow_val_q <= 32'd0;
            shadow_dp_q  <= 8'd0;
            an_n         <= 8'hFF;
            seg_n        <= 7'h7F;
            dp_n         <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_idx    <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            an_n         <= an_d;
            seg_n        <= seg_d;
            dp_n         <= dp_d;
        end
    end

endmodule

// File: tb/tb_gpio_hex_display.sv
// tb_gpio_hex_display
// Scoreboard bench: each displayed frame's expected digit drives are pushed
// when its word is applied, and a negedge monitor pops one entry at the start
// of every lit digit. The monitor also measures pulse width, gap and frame
// period; the main sequence covers reset, blanking, decode, tearing and
// enable drop/restore.

module tb_gpio_hex_display;

    localparam int TICK  = 4;
    localparam int DEADC = 1;
    localparam int FRAME = 8 * (TICK + DEADC);

    logic        clk;
    logic        rst_n;
    logic [31:0] value_in;
    logic [7:0]  dp_in;
    logic        enable;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [7:0]  an_n;
    logic [2:0]  digit_idx;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] idx;
    } exp_t;

    exp_t sb[$];

    int total_cnt;
    int bad_cnt;
    bit mon_active;
    int low_cnt;
    int high_cnt;
    int frame_cyc;
    bit have_prev;
    bit have_frame;

    gpio_hex_display #(
        .TICK_CYCLES(TICK),
        .DEAD_CYCLES(DEADC),
        .BLANK_LZ(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value_in(value_in),
        .dp_in(dp_in),
        .enable(enable),
        .seg_n(seg_n),
        .dp_n(dp_n),
        .an_n(an_n),
        .digit_idx(digit_idx)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total_cnt++;
        if (got !== expv) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    // Reference segment table and leading-zero blanking rule.
    function automatic logic [6:0] exp_seg(input logic [31:0] v, input int k);
        logic [3:0] n;
        logic [6:0] s;
        if (k > 0 && (v >> (4 * k)) == 32'd0) return 7'h7F;
        n = v[4*k +: 4];
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Waits for the previous frame's last digit to start, then drives the
    // next word and queues the eight digits it must produce.
    task automatic applyStimulus(input logic [31:0] v, input logic [7:0] dp);
        exp_t e;
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        checkOutput("drain", sb.size(), 0);
        sb.delete();
        #1;
        value_in = v;
        dp_in    = dp;
        for (int k = 0; k < 8; k++) begin
            e.an  = ~(8'b1 << k);
            e.seg = exp_seg(v, k);
            e.dp  = ~dp[k];
            e.idx = 3'(k);
            sb.push_back(e);
        end
    endtask

    task automatic waitLit(input logic [2:0] k);
        bit found;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (digit_idx == k && an_n !== 8'hFF) found = 1;
        end
        checkOutput($sformatf("find_digit%0d", k), found, 1);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_an"}, an_n, 8'hFF);
        checkOutput({tag, "_seg"}, seg_n, 7'h7F);
        checkOutput({tag, "_dp"}, dp_n, 1'b1);
        checkOutput({tag, "_idx"}, digit_idx, 3'd7);
    endtask

    // Monitor: pops one expectation per lit digit and measures scan timing.
    always @(negedge clk) begin
        if (mon_active) begin
            if (an_n === 8'hFF) begin
                if (!enable || !rst_n) begin
                    have_prev  = 0;
                    have_frame = 0;
                    low_cnt    = 0;
                    high_cnt   = 0;
                end else begin
                    if (low_cnt != 0) begin
                        checkOutput("pulse_width", low_cnt, TICK);
                        low_cnt = 0;
                    end
                    high_cnt++;
                end
            end else begin
                if (low_cnt == 0) begin
                    exp_t e;
                    if (have_prev) checkOutput("gap", high_cnt, DEADC);
                    have_prev = 1;
                    high_cnt  = 0;
                    if (digit_idx == 3'd0) begin
                        if (have_frame) checkOutput("frame_period", frame_cyc, FRAME);
                        have_frame = 1;
                        frame_cyc  = 0;
                    end
                    checkOutput("sb_avail", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        checkOutput($sformatf("an_d%0d", e.idx), an_n, e.an);
                        checkOutput($sformatf("seg_d%0d", e.idx), seg_n, e.seg);
                        checkOutput($sformatf("dp_d%0d", e.idx), dp_n, e.dp);
                        checkOutput($sformatf("idx_d%0d", e.idx), digit_idx, e.idx);
                    end
                end
                low_cnt++;
            end
            frame_cyc++;
        end
    end

    // Main sequence.
    initial begin
        total_cnt  = 0;
        bad_cnt    = 0;
        mon_active = 0;
        low_cnt    = 0;
        high_cnt   = 0;
        frame_cyc  = 0;
        have_prev  = 0;
        have_frame = 0;
        rst_n      = 1'b0;
        enable     = 1'b0;
        value_in   = 32'd0;
        dp_in      = 8'd0;

        repeat (3) @(posedge clk);
        #1 checkReset("in_reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 checkReset("idle");
        @(negedge clk) mon_active = 1;

        // Blanking, then full decode, all-zero word and dp bits.
        applyStimulus(32'h0000_00A5, 8'h02);
        enable = 1'b1;
        applyStimulus(32'h0123_4567, 8'h81);
        applyStimulus(32'h89AB_CDEF, 8'h00);
        applyStimulus(32'h0000_0000, 8'hFF);

        // Word changes mid-frame must not reach the frame in progress.
        applyStimulus(32'h1111_1111, 8'h00);
        waitLit(3'd3);
        #2 value_in = 32'h2222_2222;
        applyStimulus(32'h2222_2222, 8'h00);

        // Enable drop during digit 5, then restore with a fresh word.
        waitLit(3'd5);
        #2 enable = 1'b0;
        @(posedge clk);
        #1 checkReset("en_drop");
        sb.delete();
        repeat (3) @(negedge clk);
        applyStimulus(32'hDEAD_BEEF, 8'h10);
        enable = 1'b1;
        @(posedge clk);
        #1 checkOutput("restore_dead_an", an_n, 8'hFF);
        @(posedge clk);
        #1 checkOutput("restore_show_an", an_n, 8'hFE);
        checkOutput("restore_show_seg", seg_n, 7'h0E);

        // Asynchronous reset in the middle of the final digit.
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        checkOutput("final_drain", sb.size(), 0);
        @(negedge clk);
        #2 checkOutput("lit_before_rst", an_n !== 8'hFF, 1);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1 checkReset("async_rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 checkReset("post_rst");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
